// File: rtl/sdram_fifo_param.sv
// Parametrised synchronous FIFO between host request logic and the SDRAM sequencer.
// Show-ahead or registered read, threshold flags, sticky error flags and synchronous flush.
module sdram_fifo_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              rd_ok;
  logic              wr_ok;
  logic [LW-1:0]     level_nxt;

  // Accept decode; a write into a full FIFO rides on a same-cycle read.
  always_comb begin
    rd_ok     = rd & ~empty;
    wr_ok     = wr & (~full | rd_ok);
    level_nxt = level;
    case ({wr_ok, rd_ok})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // Storage array carries no reset; writes are dropped in reset and flush cycles.
  always_ff @(posedge clk) begin
    if (!reset && !clear && wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, fill level and flags; flags are decoded from the next level so they track level exactly.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (AF_LEVEL == 0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      level        <= level_nxt;
      full         <= (level_nxt == LW'(DEPTH));
      empty        <= (level_nxt == '0);
      almost_full  <= (level_nxt >= LW'(AF_LEVEL));
      almost_empty <= (level_nxt <= LW'(AE_LEVEL));
      if (wr && !wr_ok) overflow  <= 1'b1;
      if (rd && empty)  underflow <= 1'b1;
    end
  end

  generate
    if (FWFT != 0) begin : g_show_ahead
      assign rd_data  = mem[rd_ptr];
      assign rd_valid = ~empty;
    end else begin : g_registered
      logic [DATA_W-1:0] rd_data_q;
      logic              rd_valid_q;

      // One-cycle read latency; data holds between reads, flush leaves it untouched.
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (clear) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_ok;
          if (rd_ok) rd_data_q <= mem[rd_ptr];
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sdram_fifo_param.sv
// Bench for sdram_fifo_param: a show-ahead and a registered-read instance share one stimulus
// stream and are checked against a queue-based reference model.
module tb_sdram_fifo_param;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;
  localparam int unsigned AE    = 2;

  logic          clk = 1'b0;
  logic          reset, clear, wr, rd;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] rd_data1, rd_data0;
  logic          rd_valid1, rd_valid0;
  logic          full1, full0, empty1, empty0;
  logic          af1, af0, ae1, ae0;
  logic [3:0]    level1, level0;
  logic          ov1, ov0, un1, un0;

  logic [DW-1:0] q[$];
  bit            m_ov, m_un, m_v0;
  logic [DW-1:0] m_d0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sdram_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut (
    .clk(clk), .reset(reset), .clear(clear), .wr(wr), .wr_data(wr_data), .rd(rd),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .level(level1), .overflow(ov1), .underflow(un1));

  sdram_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .clear(clear), .wr(wr), .wr_data(wr_data), .rd(rd),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .level(level0), .overflow(ov0), .underflow(un0));

  // Drive one cycle and advance the reference model by the FIFO's accept rules.
  task automatic step(input bit w, input bit r, input bit c, input logic [DW-1:0] d);
    bit e, f, rok, wok;
    wr = w; rd = r; clear = c; wr_data = d;
    @(posedge clk);
    #1;
    if (c) begin
      q.delete(); m_ov = 0; m_un = 0; m_v0 = 0;
    end else begin
      e   = (q.size() == 0);
      f   = (q.size() == DEPTH);
      rok = r && !e;
      wok = w && (!f || rok);
      if (w && !wok) m_ov = 1;
      if (r && e)    m_un = 1;
      m_v0 = rok;
      if (rok) m_d0 = q.pop_front();
      if (wok) q.push_back(d);
    end
    wr = 0; rd = 0; clear = 0;
  endtask

  task automatic test_reset();
    reset = 1; clear = 0; wr = 0; rd = 0; wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    q.delete(); m_ov = 0; m_un = 0; m_v0 = 0; m_d0 = '0;
    n_checks++; if (level1 !== 4'd0)    begin n_fail++; $display("FAIL reset_level got %0d want 0", level1); end
    n_checks++; if (empty1 !== 1'b1)    begin n_fail++; $display("FAIL reset_empty got %b want 1", empty1); end
    n_checks++; if (ae1 !== 1'b1)       begin n_fail++; $display("FAIL reset_almost_empty got %b want 1", ae1); end
    n_checks++; if (full1 !== 1'b0)     begin n_fail++; $display("FAIL reset_full got %b want 0", full1); end
    n_checks++; if (af1 !== 1'b0)       begin n_fail++; $display("FAIL reset_almost_full got %b want 0", af1); end
    n_checks++; if (ov1 !== 1'b0)       begin n_fail++; $display("FAIL reset_overflow got %b want 0", ov1); end
    n_checks++; if (un1 !== 1'b0)       begin n_fail++; $display("FAIL reset_underflow got %b want 0", un1); end
    n_checks++; if (rd_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid1 got %b want 0", rd_valid1); end
    n_checks++; if (rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid0 got %b want 0", rd_valid0); end
    n_checks++; if (rd_data0 !== 16'h0) begin n_fail++; $display("FAIL reset_rd_data0 got %h want 0000", rd_data0); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0, 16'(i));
      n_checks++; if (level1 !== 4'(i))      begin n_fail++; $display("FAIL fill_level got %0d want %0d", level1, i); end
      n_checks++; if (full1 !== (i == 8))    begin n_fail++; $display("FAIL fill_full got %b at level %0d", full1, i); end
      n_checks++; if (af1 !== (i >= 6))      begin n_fail++; $display("FAIL fill_almost_full got %b at level %0d", af1, i); end
      n_checks++; if (ae1 !== (i <= 2))      begin n_fail++; $display("FAIL fill_almost_empty got %b at level %0d", ae1, i); end
      n_checks++; if (empty1 !== 1'b0)       begin n_fail++; $display("FAIL fill_empty got %b want 0", empty1); end
    end
    for (int i = 1; i <= 8; i++) begin
      n_checks++; if (rd_data1 !== 16'(i))   begin n_fail++; $display("FAIL drain_data got %h want %h", rd_data1, 16'(i)); end
      n_checks++; if (rd_valid1 !== 1'b1)    begin n_fail++; $display("FAIL drain_valid got %b want 1", rd_valid1); end
      step(0, 1, 0, '0);
    end
    n_checks++; if (empty1 !== 1'b1) begin n_fail++; $display("FAIL drain_empty got %b want 1", empty1); end
    n_checks++; if (level1 !== 4'd0) begin n_fail++; $display("FAIL drain_level got %0d want 0", level1); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h0100 + 16'(i));
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (rd_data1 !== 16'h0100 + 16'(i)) begin n_fail++; $display("FAIL wrap_pre got %h want %h", rd_data1, 16'h0100 + 16'(i)); end
      step(0, 1, 0, '0);
    end
    for (int i = 0; i < 8; i++) step(1, 0, 0, 16'hA000 + 16'(i));
    n_checks++; if (full1 !== 1'b1) begin n_fail++; $display("FAIL wrap_full got %b want 1", full1); end
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (rd_data1 !== 16'hA000 + 16'(i)) begin n_fail++; $display("FAIL wrap_data got %h want %h", rd_data1, 16'hA000 + 16'(i)); end
      step(0, 1, 0, '0);
    end
    n_checks++; if (empty1 !== 1'b1) begin n_fail++; $display("FAIL wrap_empty got %b want 1", empty1); end
  endtask

  task automatic test_full_boundary();
    logic [DW-1:0] exp_seq [8];
    for (int i = 1; i <= 8; i++) step(1, 0, 0, 16'(i));
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 16'hB000 + 16'(i));
      n_checks++; if (level1 !== 4'd8) begin n_fail++; $display("FAIL fullrw_level got %0d want 8", level1); end
      n_checks++; if (ov1 !== 1'b0)    begin n_fail++; $display("FAIL fullrw_overflow got %b want 0", ov1); end
      n_checks++; if (full1 !== 1'b1)  begin n_fail++; $display("FAIL fullrw_full got %b want 1", full1); end
    end
    exp_seq = '{16'h5, 16'h6, 16'h7, 16'h8, 16'hB000, 16'hB001, 16'hB002, 16'hB003};
    for (int i = 0; i < 8; i++) begin
      n_checks++; if (rd_data1 !== exp_seq[i]) begin n_fail++; $display("FAIL fullrw_data got %h want %h", rd_data1, exp_seq[i]); end
      step(0, 1, 0, '0);
    end
  endtask

  task automatic test_empty_boundary();
    step(1, 1, 0, 16'hC0DE);
    n_checks++; if (level1 !== 4'd1)       begin n_fail++; $display("FAIL emptyrw_level got %0d want 1", level1); end
    n_checks++; if (un1 !== 1'b1)          begin n_fail++; $display("FAIL emptyrw_underflow got %b want 1", un1); end
    n_checks++; if (rd_data1 !== 16'hC0DE) begin n_fail++; $display("FAIL emptyrw_data got %h want c0de", rd_data1); end
    n_checks++; if (rd_valid0 !== 1'b0)    begin n_fail++; $display("FAIL emptyrw_valid0 got %b want 0", rd_valid0); end
    for (int i = 1; i < 8; i++) step(1, 0, 0, 16'h0C00 + 16'(i));
    step(1, 0, 0, 16'hDEAD);
    n_checks++; if (ov1 !== 1'b1)          begin n_fail++; $display("FAIL ovf_flag got %b want 1", ov1); end
    n_checks++; if (level1 !== 4'd8)       begin n_fail++; $display("FAIL ovf_level got %0d want 8", level1); end
    for (int i = 0; i < 8; i++) begin
      logic [DW-1:0] e;
      e = (i == 0) ? 16'hC0DE : 16'h0C00 + 16'(i);
      n_checks++; if (rd_data1 !== e) begin n_fail++; $display("FAIL ovf_data got %h want %h", rd_data1, e); end
      step(0, 1, 0, '0);
    end
    n_checks++; if (ov1 !== 1'b1 || un1 !== 1'b1) begin n_fail++; $display("FAIL sticky got ov=%b un=%b want 1 1", ov1, un1); end
    step(1, 0, 0, 16'h0042);
    step(0, 0, 1, '0);
    n_checks++; if ({full1, empty1, af1, ae1, ov1, un1, rd_valid1} !== 7'b0101000)
      begin n_fail++; $display("FAIL clear_flags got %b want 0101000", {full1, empty1, af1, ae1, ov1, un1, rd_valid1}); end
    n_checks++; if (level1 !== 4'd0) begin n_fail++; $display("FAIL clear_level got %0d want 0", level1); end
  endtask

  task automatic test_registered_read();
    step(1, 0, 0, 16'h1234);
    step(1, 0, 0, 16'h5678);
    n_checks++; if (rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL rr_idle_valid got %b want 0", rd_valid0); end
    step(0, 1, 0, '0);
    n_checks++; if (rd_valid0 !== 1'b1 || rd_data0 !== 16'h1234) begin n_fail++; $display("FAIL rr_first got v=%b d=%h want 1 1234", rd_valid0, rd_data0); end
    step(0, 1, 0, '0);
    n_checks++; if (rd_valid0 !== 1'b1 || rd_data0 !== 16'h5678) begin n_fail++; $display("FAIL rr_second got v=%b d=%h want 1 5678", rd_valid0, rd_data0); end
    step(0, 0, 0, '0);
    n_checks++; if (rd_valid0 !== 1'b0 || rd_data0 !== 16'h5678) begin n_fail++; $display("FAIL rr_hold got v=%b d=%h want 0 5678", rd_valid0, rd_data0); end
    n_checks++; if (empty0 !== 1'b1) begin n_fail++; $display("FAIL rr_empty got %b want 1", empty0); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h0700 + 16'(i));
    n_checks++; if (level1 !== 4'd5) begin n_fail++; $display("FAIL flush_pre_level got %0d want 5", level1); end
    step(1, 1, 1, 16'h1111);
    n_checks++; if (level1 !== 4'd0 || empty1 !== 1'b1) begin n_fail++; $display("FAIL flush_level got %0d empty=%b want 0 1", level1, empty1); end
    n_checks++; if (ov1 !== 1'b0 || un1 !== 1'b0 || rd_valid0 !== 1'b0) begin n_fail++; $display("FAIL flush_flags got ov=%b un=%b v0=%b want 0 0 0", ov1, un1, rd_valid0); end
    step(1, 0, 0, 16'hFFFF);
    n_checks++; if (rd_data1 !== 16'hFFFF || level1 !== 4'd1) begin n_fail++; $display("FAIL flush_write got %h lvl %0d want ffff 1", rd_data1, level1); end
    step(0, 1, 0, '0);
    n_checks++; if (rd_data0 !== 16'hFFFF || rd_valid0 !== 1'b1) begin n_fail++; $display("FAIL flush_read0 got %h v=%b want ffff 1", rd_data0, rd_valid0); end
  endtask

  task automatic test_random();
    bit w, r, c;
    int sz;
    for (int n = 0; n < 600; n++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      c = ($urandom_range(0, 99) == 0);
      if (q.size() != 0) begin
        n_checks++; if (rd_data1 !== q[0]) begin n_fail++; $display("FAIL rnd_show got %h want %h cyc %0d", rd_data1, q[0], n); end
      end
      step(w, r, c, 16'($urandom));
      sz = q.size();
      n_checks++;
      if (level1 !== 4'(sz) || full1 !== (sz == DEPTH) || empty1 !== (sz == 0) ||
          af1 !== (sz >= AF) || ae1 !== (sz <= AE) || ov1 !== m_ov || un1 !== m_un ||
          rd_valid1 !== (sz != 0)) begin
        n_fail++;
        $display("FAIL rnd_status cyc %0d got lvl=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b v=%b want lvl=%0d ov=%b un=%b",
                 n, level1, full1, empty1, af1, ae1, ov1, un1, rd_valid1, sz, m_ov, m_un);
      end
      n_checks++;
      if (rd_valid0 !== m_v0 || rd_data0 !== m_d0 || level0 !== 4'(sz) || ov0 !== m_ov || un0 !== m_un) begin
        n_fail++;
        $display("FAIL rnd_regread cyc %0d got v=%b d=%h lvl=%0d want v=%b d=%h lvl=%0d", n, rd_valid0, rd_data0, level0, m_v0, m_d0, sz);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_boundary();
    test_empty_boundary();
    test_registered_read();
    test_flush();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
